// File: rtl/level_transition_if_pkg.sv
// Shared defaults for the level-transition handshake indicator.
// Holds only the parameter defaults so that every instantiation site agrees.
// No logic lives here.
package level_transition_if_pkg;

    // One channel by default: a single RDYIN or ACKOUT line.
    localparam int LTI_WIDTH       = 1;

    // Zero sync stages: the peer line is used combinationally.
    localparam int LTI_SYNC_STAGES = 0;

endpackage : level_transition_if_pkg

// File: rtl/level_transition_if.sv
// Level-transition handshake indicator: out = in_eff ^ S, where beta toggles S per bit.
// Latency: beta -> out just after the sampling edge; in -> out 0 cycles (N=0) or N edges.
// Backpressure: none; beta is an unconditional toggle strobe and out is a pure level.
module level_transition_if
    import level_transition_if_pkg::*;
#(
    parameter int WIDTH       = LTI_WIDTH,
    parameter int SYNC_STAGES = LTI_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] beta,
    output logic [WIDTH-1:0] out
);

    // Per-bit toggle state, gathered into one vector for the output XOR.
    logic [WIDTH-1:0] s_vec;

    // Peer line after the optional synchroniser.
    logic [WIDTH-1:0] in_eff;

    // One independent toggle flop per channel; bits never interact.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic s_q;
        logic s_d;

        // Next toggle state: beta flips the bit, otherwise it holds.
        always_comb begin
            s_d = s_q;
            if (beta[b]) begin
                s_d = ~s_q;
            end
        end

        // Toggle register; reset clears it so no X can reach out.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s_q <= 1'b0;
            end else begin
                s_q <= s_d;
            end
        end

        assign s_vec[b] = s_q;
    end : g_bit

    // Optional free-running synchroniser on the peer line.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign in_eff = in;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];
        logic [WIDTH-1:0] sync_d [SYNC_STAGES];

        // Shift pattern: stage 0 takes the raw line, each later stage takes its predecessor.
        always_comb begin
            sync_d[0] = in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        // Chain clocked every cycle with no enable; reset empties it to zero.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_d[i];
                end
            end
        end

        assign in_eff = sync_q[SYNC_STAGES-1];
    end : g_sync

    // Indicator is purely combinational; a simultaneous line change and beta cancel out.
    assign out = in_eff ^ s_vec;

endmodule : level_transition_if

// File: tb/tb_level_transition_if.sv
// Bench for level_transition_if: one combinational 1-bit instance and one 2-bit, 2-stage instance.
// Directed handshake scenarios use fixed expectations; a random phase uses a pulse-counting model.
// The model counts beta pulses (S = count mod 2) and delays the line with a sample queue.
module tb_level_transition_if;

    logic       clock;
    logic       reset;
    logic       in_a;
    logic       beta_a;
    logic       out_a;
    logic [1:0] in_b;
    logic [1:0] beta_b;
    logic [1:0] out_b;

    int n_checks;
    int n_pass;

    // Reference model state.
    int         cnt_a;
    int         cnt_b [2];
    logic [1:0] q_b [$];

    level_transition_if #(.WIDTH(1), .SYNC_STAGES(0)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .in    (in_a),
        .beta  (beta_a),
        .out   (out_a)
    );

    level_transition_if #(.WIDTH(2), .SYNC_STAGES(2)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .in    (in_b),
        .beta  (beta_b),
        .out   (out_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        cnt_a    = 0;
        cnt_b[0] = 0;
        cnt_b[1] = 0;
        q_b      = {2'b00, 2'b00};
    endfunction

    function automatic logic [1:0] exp_a();
        return {1'b0, in_a ^ cnt_a[0]};
    endfunction

    function automatic logic [1:0] exp_b();
        logic [1:0] s;
        s = {cnt_b[1][0], cnt_b[0][0]};
        return q_b[0] ^ s;
    endfunction

    // Advance one rising edge, apply the model's view of what the DUT sampled, settle 1 time unit.
    task automatic tick();
        logic [1:0] dummy;
        @(posedge clock);
        if (!reset) begin
            if (beta_a) cnt_a++;
            for (int b = 0; b < 2; b++) begin
                if (beta_b[b]) cnt_b[b]++;
            end
            q_b.push_back(in_b);
            dummy = q_b.pop_front();
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a"}, {1'b0, out_a}, exp_a());
        chk({tag, "_b"}, out_b, exp_b());
    endtask

    // Assert reset between edges, then release it before the next edge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] held;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        in_a     = 1'b0;
        beta_a   = 1'b0;
        in_b     = 2'b00;
        beta_b   = 2'b00;
        model_reset();

        // Reset state: out follows in for N=0, zero for the synchronised instance.
        #3;
        chk("rst_a_in0", {1'b0, out_a}, 2'b00);
        chk("rst_b", out_b, 2'b00);
        in_a = 1'b1;
        in_b = 2'b11;
        #1;
        chk("rst_a_in1", {1'b0, out_a}, 2'b01);
        tick();
        chk("rst_b_held", out_b, 2'b00);
        in_a = 1'b0;
        in_b = 2'b00;
        #2;
        reset = 1'b0;
        #1;

        // Ack mode: three single-cycle beta pulses -> 1,0,1.
        chk("ack_init", {1'b0, out_a}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            beta_a = 1'b1;
            tick();
            beta_a = 1'b0;
            #1;
            chk($sformatf("ack_pulse%0d", i), {1'b0, out_a}, (i % 2 == 0) ? 2'b01 : 2'b00);
        end

        // Rdy mode from a clean state.
        pulse_reset();
        in_a = 1'b1;
        #1;
        chk("rdy_req", {1'b0, out_a}, 2'b01);
        beta_a = 1'b1;
        tick();
        beta_a = 1'b0;
        chk("rdy_ack", {1'b0, out_a}, 2'b00);
        in_a = 1'b0;
        #1;
        chk("rdy_req2", {1'b0, out_a}, 2'b01);
        beta_a = 1'b1;
        tick();
        beta_a = 1'b0;
        chk("rdy_ack2", {1'b0, out_a}, 2'b00);

        // Hold: no beta, no line change for 10 cycles.
        held = {1'b0, out_a};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold", {1'b0, out_a}, held);
        end

        // Simultaneous line rise and beta: glitch high, then back low after the edge.
        pulse_reset();
        in_a   = 1'b1;
        beta_a = 1'b1;
        #1;
        chk("simul_glitch", {1'b0, out_a}, 2'b01);
        tick();
        beta_a = 1'b0;
        chk("simul_after", {1'b0, out_a}, 2'b00);

        // Reset mid-handshake: S=1, in=1 -> out=0; reset drops S at once.
        chk("midrst_before", {1'b0, out_a}, 2'b00);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_during", {1'b0, out_a}, 2'b01);
        reset = 1'b0;
        tick();
        chk("midrst_release", {1'b0, out_a}, 2'b01);
        beta_a = 1'b1;
        tick();
        beta_a = 1'b0;
        chk("midrst_ack", {1'b0, out_a}, 2'b00);
        in_a = 1'b0;

        // Synchronised instance: line visible after exactly 2 edges, beta on bit 1.
        pulse_reset();
        in_b = 2'b01;
        #1;
        chk("sync_edge0", out_b, 2'b00);
        tick();
        chk("sync_edge1", out_b, 2'b00);
        tick();
        chk("sync_edge2", out_b, 2'b01);
        beta_b = 2'b10;
        tick();
        beta_b = 2'b00;
        chk("sync_beta", out_b, 2'b11);

        // Random phase against the model, with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            in_a   = 1'($urandom);
            beta_a = 1'($urandom);
            in_b   = 2'($urandom);
            beta_b = 2'($urandom);
            #1;
            check_all("rnd_comb");
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all("rnd_rst");
                reset = 1'b0;
            end
            tick();
            check_all("rnd_edge");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_level_transition_if
